uart_rx_sampler: RTL and testbench

- Serial-to-parallel UART receiver that feeds the switch/LED I/O interface with received bytes.
- Frame format: 8N1, LSB first, idle-high line.
- Synchronises the asynchronous rx pin, validates the start bit at mid-bit, and samples each bit at its centre.
- Delivers each byte with a one-cycle ready strobe and flags framing errors; it sits between the board RX pin and the byte consumer.

---
 rtl/uart_rx_sampler.sv | 83 ++++++++
 tb/tb_uart_rx_sampler.sv | 121 ++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 UART receiver with mid-bit sampling, ready strobe and framing-error flag
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       ready,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_BIT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} state_t;

    state_t        state;
    logic          rx_meta, rx_s;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            ready     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            ready     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: if (!rx_s) begin
                    state   <= START;
                    clk_cnt <= '0;
                    busy    <= 1'b1;
                end
                START: if (clk_cnt == HALF_BIT) begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    state   <= rx_s ? IDLE : DATA;
                    busy    <= !rx_s;
                end else clk_cnt <= clk_cnt + 1'b1;
                DATA: if (clk_cnt == LAST) begin
                    shift[bit_idx] <= rx_s;
                    clk_cnt        <= '0;
                    bit_idx        <= bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state <= STOP;
                end else clk_cnt <= clk_cnt + 1'b1;
                STOP: if (clk_cnt == LAST) begin
                    clk_cnt <= '0;
                    if (rx_s) begin
                        data  <= shift;
                        ready <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= BREAK_WAIT;
                    end
                end else clk_cnt <= clk_cnt + 1'b1;
                BREAK_WAIT: if (rx_s) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed frames checked against a queue of expected receive events
module tb_uart_rx_sampler;
    localparam int CPB = 16;

    logic       clk = 1'b0, rst = 1'b1, rx = 1'b1;
    logic [7:0] data;
    logic       ready, frame_err, busy;
    int         checks = 0, failures = 0, cyc = 0;

    typedef struct {logic err; logic [7:0] b; int t;} exp_t;
    exp_t       q[$];
    logic [7:0] model_data = 8'h00;

    uart_rx_sampler #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data),
        .ready(ready), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Expected behaviour: every good frame yields one ready with its byte ~9.5 bits after the
    // start edge, every bad stop bit yields one frame_err, and data holds the last good byte.
    always @(negedge clk) begin
        if (rst) begin
            model_data = 8'h00;
            chk("rst_data", data, 8'h00);
            chk("rst_flags", {ready, frame_err, busy}, 3'b000);
        end else begin
            chk("not_both", ready & frame_err, 1'b0);
            if (ready || frame_err) begin
                if (q.size() == 0) chk("unexpected_pulse", {ready, frame_err}, 2'b00);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pulse_kind", {ready, frame_err}, e.err ? 2'b01 : 2'b10);
                    if (!e.err) begin
                        model_data = e.b;
                        chk("latency_ok", (cyc - e.t) >= 152 && (cyc - e.t) <= 156, 1'b1);
                    end
                end
            end
            chk("data", data, model_data);
        end
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        q.push_back('{err: !stop_bit, b: b, t: cyc});
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop_bit, CPB);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        hold(1'b1, 1000);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        hold(1'b1, 20);

        send(8'hA5, 1'b1);
        hold(1'b1, 10);
        chk("pin_a5", data, 8'hA5);

        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h3C, 1'b1);
        hold(1'b1, 10);
        chk("pin_3c", data, 8'h3C);

        rx = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) chk("glitch_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        hold(1'b1, 20);
        chk("glitch_idle", busy, 1'b0);

        send(8'h55, 1'b0);
        hold(1'b0, 40 * CPB);
        chk("break_busy", busy, 1'b1);
        hold(1'b1, 2 * CPB);
        chk("pin_hold_3c", data, 8'h3C);
        send(8'h81, 1'b1);
        hold(1'b1, 10);
        chk("pin_81", data, 8'h81);

        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(logic'((8'hC3 >> i) & 1), CPB);
        hold(1'b1, CPB / 2);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("pin_abort_00", data, 8'h00);
        hold(1'b1, 40);
        send(8'h12, 1'b1);
        hold(1'b1, 10);
        chk("pin_12", data, 8'h12);

        for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
        chk("all_events_seen", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
